// File: rtl/seq_pkg.sv
// Shared defaults and the fill-counter width helper for the serial pattern detector.
package seq_pkg;

  localparam int         PAT_LEN_DEF = 4;
  localparam logic [3:0] PAT_DEF     = 4'b0110;
  localparam int         CNT_W_DEF   = 8;

  // Bits needed to hold 0..pat_len, i.e. clog2(pat_len+1).
  function automatic int fill_width(input int pat_len);
    int w;
    w = 0;
    for (int v = pat_len; v > 0; v = v >> 1) begin
      w = w + 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/seq_sat_cnt.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module seq_sat_cnt #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else if (clr) begin
      q <= '0;
    end else if (inc && (q != {W{1'b1}})) begin
      q <= q + 1'b1;
    end
  end

endmodule

// File: rtl/seq_detect_param.sv
// Serial pattern detector with loadable pattern, optional overlap and a saturating match count.
module seq_detect_param
  import seq_pkg::*;
#(
  parameter int                 PAT_LEN  = PAT_LEN_DEF,
  parameter logic [PAT_LEN-1:0] PAT_INIT = PAT_LEN'(PAT_DEF),
  parameter int                 OVERLAP  = 1,
  parameter int                 CNT_W    = CNT_W_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en,
  input  logic               i,
  input  logic               pat_load,
  input  logic [PAT_LEN-1:0] pat_in,
  input  logic               cnt_clr,
  output logic               out,
  output logic [CNT_W-1:0]   match_cnt
);

  localparam int            FW   = fill_width(PAT_LEN);
  localparam logic [FW-1:0] FULL = FW'(PAT_LEN);

  logic [PAT_LEN-1:0] pat;
  logic [PAT_LEN-1:0] hist;
  logic [PAT_LEN-1:0] hist_next;
  logic [FW-1:0]      fill;
  logic [FW-1:0]      fill_inc;
  logic [FW-1:0]      fill_next;
  logic               match;

  // A match is judged on the post-shift history so the pulse lands on the completing edge.
  always_comb begin
    hist_next = (hist << 1) | {{(PAT_LEN-1){1'b0}}, i};
    fill_inc  = (fill == FULL) ? FULL : fill + 1'b1;
    match     = en && !pat_load && (hist_next == pat) && (fill_inc == FULL);
    fill_next = fill_inc;
    if (match && (OVERLAP == 0)) begin
      fill_next = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pat  <= PAT_INIT;
      hist <= '0;
      fill <= '0;
      out  <= 1'b0;
    end else if (pat_load) begin
      pat  <= pat_in;
      fill <= '0;
      out  <= 1'b0;
    end else if (en) begin
      hist <= hist_next;
      fill <= fill_next;
      out  <= match;
    end else begin
      out  <= 1'b0;
    end
  end

  seq_sat_cnt #(
    .W(CNT_W)
  ) u_cnt (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (cnt_clr),
    .inc  (match),
    .q    (match_cnt)
  );

endmodule

// File: tb/tb_seq_detect_param.sv
// Directed bench: three detector instances (default, non-overlapping, 2-bit counter) on shared stimulus.
module tb_seq_detect_param;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en = 1'b0;
  logic       i = 1'b0;
  logic       pat_load = 1'b0;
  logic [3:0] pat_in = 4'b0000;
  logic       cnt_clr = 1'b0;

  logic       out_a, out_b, out_c;
  logic [7:0] cnt_a, cnt_b;
  logic [1:0] cnt_c;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  seq_detect_param dut_a (
    .clk(clk), .rst_n(rst_n), .en(en), .i(i), .pat_load(pat_load),
    .pat_in(pat_in), .cnt_clr(cnt_clr), .out(out_a), .match_cnt(cnt_a)
  );

  seq_detect_param #(.OVERLAP(0)) dut_b (
    .clk(clk), .rst_n(rst_n), .en(en), .i(i), .pat_load(pat_load),
    .pat_in(pat_in), .cnt_clr(cnt_clr), .out(out_b), .match_cnt(cnt_b)
  );

  seq_detect_param #(.CNT_W(2)) dut_c (
    .clk(clk), .rst_n(rst_n), .en(en), .i(i), .pat_load(pat_load),
    .pat_in(pat_in), .cnt_clr(cnt_clr), .out(out_c), .match_cnt(cnt_c)
  );

  // Drive one cycle of stimulus, then sample 1ns after the rising edge.
  task automatic send_bit(input logic b, input logic e, input logic clr, input logic ld);
    i        = b;
    en       = e;
    cnt_clr  = clr;
    pat_load = ld;
    @(posedge clk);
    #1;
    $display("t=%0t i=%0b en=%0b clr=%0b ld=%0b | out a/b/c=%0b%0b%0b cnt a/b/c=%0d/%0d/%0d",
             $time, b, e, clr, ld, out_a, out_b, out_c, cnt_a, cnt_b, cnt_c);
    en       = 1'b0;
    cnt_clr  = 1'b0;
    pat_load = 1'b0;
  endtask

  // Pulse reset between edges; leaves time at posedge+3.
  task automatic do_reset();
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if ({out_a, out_b, out_c} !== 3'b000) begin
      failures++;
      $display("FAIL reset_out: got %b want 000", {out_a, out_b, out_c});
    end
    checks++;
    if (cnt_a !== 8'd0 || cnt_b !== 8'd0 || cnt_c !== 2'd0) begin
      failures++;
      $display("FAIL reset_cnt: got %0d/%0d/%0d want 0/0/0", cnt_a, cnt_b, cnt_c);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_overlap();
    logic [6:0] stream;
    logic [6:0] exp_a;
    logic [6:0] exp_b;
    stream = 7'b0110110;
    exp_a  = 7'b0001001;
    exp_b  = 7'b0001000;
    do_reset();
    for (int k = 6; k >= 0; k--) begin
      send_bit(stream[k], 1'b1, 1'b0, 1'b0);
      checks++;
      if (out_a !== exp_a[k]) begin
        failures++;
        $display("FAIL overlap_out bit%0d: got %b want %b", 6 - k, out_a, exp_a[k]);
      end
      checks++;
      if (out_b !== exp_b[k]) begin
        failures++;
        $display("FAIL nonoverlap_out bit%0d: got %b want %b", 6 - k, out_b, exp_b[k]);
      end
    end
    checks++;
    if (cnt_a !== 8'd2) begin
      failures++;
      $display("FAIL overlap_cnt: got %0d want 2", cnt_a);
    end
    checks++;
    if (cnt_b !== 8'd1) begin
      failures++;
      $display("FAIL nonoverlap_cnt: got %0d want 1", cnt_b);
    end
  endtask

  task automatic test_en_gap();
    logic [6:0] bits;
    logic [6:0] ens;
    logic [6:0] exp;
    bits = 7'b0111110;
    ens  = 7'b1100011;
    exp  = 7'b0000001;
    do_reset();
    for (int k = 6; k >= 0; k--) begin
      send_bit(bits[k], ens[k], 1'b0, 1'b0);
      checks++;
      if (out_a !== exp[k]) begin
        failures++;
        $display("FAIL en_gap_out step%0d: got %b want %b", 6 - k, out_a, exp[k]);
      end
    end
    checks++;
    if (cnt_a !== 8'd1) begin
      failures++;
      $display("FAIL en_gap_cnt: got %0d want 1", cnt_a);
    end
  endtask

  task automatic test_pat_load();
    logic [4:0] bits;
    logic [4:0] exp;
    bits = 5'b01111;
    exp  = 5'b00001;
    do_reset();
    send_bit(1'b0, 1'b1, 1'b0, 1'b0);
    send_bit(1'b1, 1'b1, 1'b0, 1'b0);
    send_bit(1'b1, 1'b1, 1'b0, 1'b0);
    pat_in = 4'b1111;
    send_bit(1'b1, 1'b1, 1'b0, 1'b1);
    checks++;
    if (out_a !== 1'b0) begin
      failures++;
      $display("FAIL load_cycle_out: got %b want 0", out_a);
    end
    // First 0 would complete the old 0110; then 1111 needs four fresh ones.
    for (int k = 4; k >= 0; k--) begin
      send_bit(bits[k], 1'b1, 1'b0, 1'b0);
      checks++;
      if (out_a !== exp[k]) begin
        failures++;
        $display("FAIL pat_load_out step%0d: got %b want %b", 4 - k, out_a, exp[k]);
      end
    end
    checks++;
    if (cnt_a !== 8'd1) begin
      failures++;
      $display("FAIL pat_load_cnt: got %0d want 1", cnt_a);
    end
  endtask

  task automatic test_saturate();
    logic [1:0] exp_cnt;
    do_reset();
    send_bit(1'b0, 1'b1, 1'b0, 1'b0);
    for (int m = 1; m <= 6; m++) begin
      send_bit(1'b1, 1'b1, 1'b0, 1'b0);
      send_bit(1'b1, 1'b1, 1'b0, 1'b0);
      send_bit(1'b0, 1'b1, (m == 6), 1'b0);
      exp_cnt = (m == 6) ? 2'd0 : ((m >= 3) ? 2'd3 : 2'(m));
      checks++;
      if (out_c !== 1'b1) begin
        failures++;
        $display("FAIL sat_out match%0d: got %b want 1", m, out_c);
      end
      checks++;
      if (cnt_c !== exp_cnt) begin
        failures++;
        $display("FAIL sat_cnt match%0d: got %0d want %0d", m, cnt_c, exp_cnt);
      end
    end
    checks++;
    if (cnt_a !== 8'd0) begin
      failures++;
      $display("FAIL clr_cnt_wide: got %0d want 0", cnt_a);
    end
  endtask

  task automatic test_reset_mid();
    logic [3:0] bits;
    do_reset();
    bits = 4'b0110;
    for (int k = 3; k >= 0; k--) send_bit(bits[k], 1'b1, 1'b0, 1'b0);
    checks++;
    if (out_a !== 1'b1 || cnt_a !== 8'd1) begin
      failures++;
      $display("FAIL pre_reset: got out=%b cnt=%0d want out=1 cnt=1", out_a, cnt_a);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (out_a !== 1'b0 || cnt_a !== 8'd0) begin
      failures++;
      $display("FAIL async_reset: got out=%b cnt=%0d want out=0 cnt=0", out_a, cnt_a);
    end
    rst_n = 1'b1;
    send_bit(1'b0, 1'b1, 1'b0, 1'b0);
    send_bit(1'b1, 1'b1, 1'b0, 1'b0);
    send_bit(1'b1, 1'b1, 1'b0, 1'b0);
    do_reset();
    send_bit(1'b0, 1'b1, 1'b0, 1'b0);
    checks++;
    if (out_a !== 1'b0) begin
      failures++;
      $display("FAIL reset_discard: got %b want 0", out_a);
    end
    for (int k = 3; k >= 0; k--) begin
      send_bit(bits[k], 1'b1, 1'b0, 1'b0);
      checks++;
      if (out_a !== (k == 0)) begin
        failures++;
        $display("FAIL post_reset_out step%0d: got %b want %b", 3 - k, out_a, (k == 0));
      end
    end
    checks++;
    if (cnt_a !== 8'd1) begin
      failures++;
      $display("FAIL post_reset_cnt: got %0d want 1", cnt_a);
    end
  endtask

  initial begin
    test_reset();
    test_overlap();
    test_en_gap();
    test_pat_load();
    test_saturate();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/seq_detect_param.md
SEQ_DETECT_PARAM -- requirements
Module: seq_detect_param

Interface
REQ-001 SHALL have parameter PAT_LEN, default 4, pattern length in bits, legal range 2..16.
REQ-002 SHALL have parameter PAT_INIT, default 4'b0110 (PAT_LEN bits), the pattern loaded at reset, MSB first in time.
REQ-003 SHALL have parameter OVERLAP, default 1: 1 = overlapping matches allowed, 0 = non-overlapping.
REQ-004 SHALL have parameter CNT_W, default 8, width of the match counter.
REQ-005 SHALL have port clk, input, 1, single clock, rising edge.
REQ-006 SHALL have port rst_n, input, 1, reset, asynchronous and active-low.
REQ-007 SHALL have port en, input, 1, qualifies i as a valid serial bit this cycle.
REQ-008 SHALL have port i, input, 1, serial data bit.
REQ-009 SHALL have port pat_load, input, 1, loads pat_in as the new pattern.
REQ-010 SHALL have port pat_in, input, PAT_LEN, new pattern, MSB oldest.
REQ-011 SHALL have port cnt_clr, input, 1, synchronous clear of match_cnt.
REQ-012 SHALL have port out, output, 1, registered one-cycle match pulse.
REQ-013 SHALL have port match_cnt, output, CNT_W, saturating count of matches.

Function
REQ-014 SHALL hold the pattern register pat, a PAT_LEN-bit history register hist and a fill counter fill (0..PAT_LEN, saturating).
REQ-015 When en=1 and pat_load=0, each edge SHALL do hist <= {hist[PAT_LEN-2:0], i} and fill <= min(fill+1, PAT_LEN).
REQ-016 A match SHALL exist on an edge when the updated hist equals pat and the updated fill equals PAT_LEN.
REQ-017 out SHALL be set to 1 at the same edge that samples the completing bit and SHALL be 0 at every other edge, giving one-cycle latency from bit sample to visible pulse.
REQ-018 With OVERLAP=1, fill SHALL be unchanged after a match, so the suffix of a matched pattern is reused.
REQ-019 With OVERLAP=0, fill SHALL be set to 0 on a match, so the next match needs PAT_LEN fresh bits.
REQ-020 When en=0, hist and fill SHALL hold, and out SHALL be 0.
REQ-021 pat_load=1 SHALL set pat <= pat_in, fill <= 0 and out <= 0, and SHALL discard i that cycle regardless of en.
REQ-022 match_cnt SHALL increment by 1 on each match and SHALL saturate at 2^CNT_W-1.
REQ-023 cnt_clr=1 SHALL set match_cnt to 0, and SHALL take priority over a simultaneous match; out still pulses.
REQ-024 There SHALL be no latches, and all outputs SHALL come directly from flops.

Reset
REQ-025 rst_n=0 SHALL asynchronously set pat=PAT_INIT, hist=0, fill=0, out=0 and match_cnt=0.
REQ-026 Reset assertion mid-pattern SHALL discard partial progress; after release a full PAT_LEN bits are needed for a match.
REQ-027 Reset deassertion SHALL be treated as synchronous to clk by the integrator; the block adds no synchroniser.

Structure
REQ-028 Shared package seq_pkg SHALL hold the default constants (PAT_LEN_DEF=4, PAT_DEF=4'b0110, CNT_W_DEF=8) and the fill-width function clog2(PAT_LEN+1).
REQ-029 The saturating counter SHALL be the single sub-module seq_sat_cnt, with parameter W and ports clk, rst_n, clr, inc, q.
REQ-030 The history, fill and compare logic SHALL stay in seq_detect_param; no FSM encoding is exposed.

Verification
REQ-031 With defaults, OVERLAP=1 and en=1, the stream 0,1,1,0,1,1,0 SHALL give out=1 after the 4th and 7th bits, ending with match_cnt=2.
REQ-032 With OVERLAP=0 and the same stream, out SHALL pulse after the 4th bit only, ending with match_cnt=1.
REQ-033 With stream 0,1,en=0 for 3 cycles,1,0, out SHALL stay 0 during the en=0 gap and pulse after the final 0; match_cnt=1.
REQ-034 pat_load with pat_in=4'b1111 after bits 0,1,1 SHALL require bits 1,1,1,1 for the next pulse, and the old pattern 0110 SHALL no longer match.
REQ-035 With CNT_W=2 and 5 matches, match_cnt SHALL reach 3 and hold; cnt_clr coincident with the 6th match SHALL give match_cnt=0 and out=1.
REQ-036 rst_n pulsed low after bits 0,1,1 followed by bit 0 SHALL give no pulse, and the next 0,1,1,0 SHALL give a pulse; out SHALL be 0 asynchronously during reset.
